// File: rtl/sc_apc_layer.sv
// sc_apc_layer: multi-neuron stochastic-computing layer.
// M neurons share one N-bit input bit-slice per cycle. For each neuron, every
// accepted slice goes through three registered stages:
//   1. N products (XNOR in bipolar mode, AND in unipolar mode) counted
//      together with the bias bit.
//   2. A saturating S-bit up/down state update that acts as a Btanh
//      activation: the step is 2*cnt-(N+1) and the result is clamped to
//      0..2^S-1.
//   3. dout = MSB of the updated state, plus a per-neuron count of ones.
// A frame holds L slices. It starts with a start pulse while idle and ends
// with a one-cycle done pulse after the L-th output bit has been emitted.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, mode        begin a frame (sampled only when idle); mode 0 = bipolar,
//                      1 = unipolar, latched at start
//   in_valid/in_ready  slice handshake for din/weight/bias
//   din [N]            input bits shared by all neurons
//   weight [M*N]       neuron j uses weight[j*N +: N]
//   bias [M]           one bias bit per neuron
//   dout [M]           activation bit per neuron, held while dout_valid=0
//   dout_valid         dout carries a new bit (3 cycles after accept)
//   busy, done         frame in progress / end-of-frame pulse
//   ones_count [M*LW]  per-neuron ones in dout this frame, held until next start
module sc_apc_layer #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int S = 8,
  parameter int L = 256,
  localparam int CW = $clog2(N + 2),
  localparam int LW = $clog2(L + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    din,
  input  logic [M*N-1:0]  weight,
  input  logic [M-1:0]    bias,
  output logic [M-1:0]    dout,
  output logic            dout_valid,
  output logic            busy,
  output logic            done,
  output logic [M*LW-1:0] ones_count
);

  // The state sum is two bits wider than the state, so it can hold both a
  // negative step below zero and a positive step above 2^S-1 without wrapping.
  localparam int SW = S + 2;
  localparam logic [S-1:0]  ST_MID = {1'b1, {(S-1){1'b0}}};
  localparam logic [LW-1:0] L_CNT  = LW'(L);
  localparam logic [LW-1:0] L_LAST = LW'(L - 1);
  localparam logic [SW-1:0] NP1    = SW'(N + 1);

  typedef enum logic {ST_IDLE, ST_RUN} fsm_e;

  fsm_e fsm_q, fsm_d;

  logic          mode_q;
  logic [LW-1:0] acc_q;
  logic          accept, start_ok, frame_end;
  logic          v1_q, last1_q, v2_q, last2_q, last3_q;

  logic [CW-1:0] cnt_d  [M];
  logic [CW-1:0] cnt1_q [M];
  logic [S-1:0]  st_q   [M];
  logic [S-1:0]  st_d   [M];
  logic [SW-1:0] step_w [M];
  logic [SW-1:0] sum_w  [M];
  logic [LW-1:0] ones_q [M];

  // A start that coincides with the done pulse is ignored. New frames begin
  // on the cycle after done.
  assign start_ok  = (fsm_q == ST_IDLE) && start && !done;
  assign accept    = in_valid && in_ready;
  assign frame_end = dout_valid && last3_q;

  // ---------------- frame FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: every clocked block uses non-blocking assignments, so all
    // registers sample pre-edge values and the pipeline stages do not race.
    if (reset) fsm_q <= ST_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    // NOTE: defaulting fsm_d before the case keeps every path assigned, so no
    // latch is inferred.
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (start_ok)  fsm_d = ST_RUN;
      ST_RUN:  if (frame_end) fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (fsm_q == ST_RUN);
    in_ready = busy && (acc_q < L_CNT);
  end

  // ---------------- stage 1 combinational: products + bias popcount ----------------
  always_comb begin
    for (int j = 0; j < M; j++) begin
      cnt_d[j] = CW'(bias[j]);
      for (int i = 0; i < N; i++) begin
        cnt_d[j] = cnt_d[j] + CW'(mode_q ? (din[i] & weight[j*N+i])
                                         : ~(din[i] ^ weight[j*N+i]));
      end
    end
  end

  // ---------------- stage 2 combinational: saturating state update ----------------
  always_comb begin
    for (int j = 0; j < M; j++) begin
      step_w[j] = (SW'(cnt1_q[j]) << 1) - NP1;
      sum_w[j]  = {2'b00, st_q[j]} + step_w[j];
      if (sum_w[j][SW-1])              st_d[j] = '0;  // went below zero
      else if (sum_w[j][SW-2:S] != '0) st_d[j] = '1;  // went above 2^S-1
      else                             st_d[j] = sum_w[j][S-1:0];
    end
  end

  // NOTE: the stage-1 count is only read when v1_q is set, so it has no
  // reset. The valid bits alone carry the pipeline's reset state.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < M; j++) cnt1_q[j] <= cnt_d[j];
    end
  end

  // ---------------- control, state and output registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= 1'b0;
      acc_q      <= '0;
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      v2_q       <= 1'b0;
      last2_q    <= 1'b0;
      last3_q    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      for (int j = 0; j < M; j++) begin
        st_q[j]   <= ST_MID;
        ones_q[j] <= '0;
      end
    end else begin
      done       <= frame_end;
      v1_q       <= accept;
      last1_q    <= accept && (acc_q == L_LAST);
      v2_q       <= v1_q;
      last2_q    <= last1_q;
      dout_valid <= v2_q;
      last3_q    <= v2_q && last2_q;

      if (start_ok) begin
        mode_q <= mode;
        acc_q  <= '0;
        for (int j = 0; j < M; j++) begin
          st_q[j]   <= ST_MID;
          ones_q[j] <= '0;
        end
      end

      if (accept) acc_q <= acc_q + LW'(1);

      if (v1_q) begin
        for (int j = 0; j < M; j++) st_q[j] <= st_d[j];
      end

      // Stage 3: st_q already holds the state updated by this slice.
      if (v2_q) begin
        for (int j = 0; j < M; j++) begin
          dout[j]   <= st_q[j][S-1];
          ones_q[j] <= ones_q[j] + LW'(st_q[j][S-1]);
        end
      end
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_ones
    assign ones_count[j*LW +: LW] = ones_q[j];
  end

endmodule

// File: tb/tb_sc_apc_layer.sv
// Self-checking bench for sc_apc_layer (N=8, M=2, S=8, L=16).
// The reference model steps integer neuron states from the arithmetic rules:
// count, step, clamp, then take the MSB. It queues each expected output bit
// with the cycle on which it must appear. A negedge monitor compares every
// cycle's dout_valid/dout/done/busy and the final ones_count against it.
module tb_sc_apc_layer;
  localparam int N  = 8;
  localparam int M  = 2;
  localparam int S  = 8;
  localparam int L  = 16;
  localparam int LW = $clog2(L + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic           in_valid = 1'b0;
  logic [N-1:0]   din = '0;
  logic [M*N-1:0] weight = '0;
  logic [M-1:0]   bias = '0;
  logic           in_ready, dout_valid, busy, done;
  logic [M-1:0]   dout;
  logic [M*LW-1:0] ones_count;

  sc_apc_layer #(.N(N), .M(M), .S(S), .L(L)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .din(din), .weight(weight),
    .bias(bias), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .done(done), .ones_count(ones_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int cyc;
    int bits;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc = -1;
  int   exp_ones[M];
  int   last_dout = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_ones"}, ones_count, 0);
  endtask

  // Per-cycle monitor
  always @(negedge clk) begin
    bit exp_dv;
    if (mon_en) begin
      exp_dv = (exp_q.size() > 0) && (exp_q[0].cyc == cycle);
      check("dout_valid", dout_valid, exp_dv);
      if (exp_dv) begin
        last_dout = exp_q[0].bits;
        void'(exp_q.pop_front());
      end
      check("dout", dout, last_dout);
      check("done", done, cycle == done_cyc);
      if (cycle == done_cyc - 1) check("busy_before_done", busy, 1);
      if (cycle == done_cyc) begin
        check("busy_at_done", busy, 0);
        for (int j = 0; j < M; j++)
          check($sformatf("ones_count%0d", j), ones_count[j*LW +: LW], exp_ones[j]);
      end
    end
  end

  // Stimulus kinds: 0 din=weight,bias=1  1 din=~weight,bias=0
  // 2 four mismatches, bias0=1/bias1=0  3 fully random
  // 4 din=FF,w=0F,bias=0  5 din=FF,w=FF,bias=1
  task automatic gen_slice(input int kind);
    logic [N-1:0] msk;
    din = N'($urandom);
    for (int j = 0; j < M; j++) begin
      msk = ($urandom_range(0, 1) == 1) ? 8'h0F : 8'hF0;
      case (kind)
        0: begin weight[j*N +: N] = din;        bias[j] = 1'b1; end
        1: begin weight[j*N +: N] = ~din;       bias[j] = 1'b0; end
        2: begin weight[j*N +: N] = din ^ msk;  bias[j] = (j == 0); end
        3: begin weight[j*N +: N] = N'($urandom); bias[j] = 1'($urandom); end
        4: begin din = 8'hFF; weight[j*N +: N] = 8'h0F; bias[j] = 1'b0; end
        default: begin din = 8'hFF; weight[j*N +: N] = 8'hFF; bias[j] = 1'b1; end
      endcase
    end
  endtask

  task automatic run_frame(input string name, input bit m, input int kind,
                           input bit stall, input int abort_after,
                           input int want0, input int want1);
    int st[M];
    int acc, cyc, cnt, bits, t;
    done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;  // mode must have been latched at start
    for (int j = 0; j < M; j++) begin
      st[j] = 1 << (S - 1);
      exp_ones[j] = 0;
    end
    acc = 0; cyc = 0;
    while (acc < L && cyc < 200) begin
      gen_slice(kind);
      in_valid = stall ? (cyc % 2 == 0) : 1'b1;
      start    = stall && (cyc == 3);  // must be ignored while busy
      @(negedge clk);
      check({name, "_in_ready"}, in_ready, 1);
      if (in_valid) begin
        bits = 0;
        for (int j = 0; j < M; j++) begin
          cnt = bias[j];
          for (int i = 0; i < N; i++)
            cnt += m ? (din[i] & weight[j*N+i]) : (din[i] == weight[j*N+i]);
          st[j] = st[j] + 2 * cnt - (N + 1);
          if (st[j] < 0) st[j] = 0;
          if (st[j] > (1 << S) - 1) st[j] = (1 << S) - 1;
          if (st[j] >= (1 << (S - 1))) begin
            bits |= 1 << j;
            exp_ones[j]++;
          end
        end
        exp_q.push_back('{cycle + 3, bits});
        acc++;
        if (acc == L) done_cyc = cycle + 4;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && acc == abort_after) break;
    end
    in_valid = 1'b0;
    start = 1'b0;

    if (abort_after > 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      done_cyc = -1;
      last_dout = 0;
      @(negedge clk);
      check_reset_vals({name, "_rst"});
      reset = 1'b0;
      repeat (8) @(posedge clk);  // monitor checks that no done appears
      #1;
      return;
    end

    if (acc < L) begin
      check({name, "_accept_timeout"}, acc, L);
      return;
    end
    @(negedge clk);
    check({name, "_ready_low"}, in_ready, 0);
    t = 0;
    while (cycle <= done_cyc && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check({name, "_done_timeout"}, 0, 1);
    if (want0 >= 0) check({name, "_ones0_held"}, ones_count[0 +: LW], want0);
    if (want1 >= 0) check({name, "_ones1_held"}, ones_count[LW +: LW], want1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    run_frame("sat_up",     1'b0, 0, 1'b0, 0, 16, 16);
    run_frame("sat_down",   1'b0, 1, 1'b0, 0,  0,  0);
    run_frame("indep",      1'b0, 2, 1'b0, 0, 16,  0);
    run_frame("uni_0f",     1'b1, 4, 1'b0, 0,  0,  0);
    run_frame("bip_0f",     1'b0, 4, 1'b0, 0,  0,  0);
    run_frame("uni_ff",     1'b1, 5, 1'b0, 0, 16, 16);
    run_frame("stall_up",   1'b0, 0, 1'b1, 0, 16, 16);
    run_frame("stall_rand", 1'b0, 3, 1'b1, 0, -1, -1);
    run_frame("rand_bip",   1'b0, 3, 1'b0, 0, -1, -1);
    run_frame("rand_uni",   1'b1, 3, 1'b0, 0, -1, -1);
    run_frame("abort",      1'b0, 0, 1'b0, 7, -1, -1);
    run_frame("post_abort", 1'b0, 2, 1'b0, 0, 16,  0);
    run_frame("rand_end",   1'b0, 3, 1'b0, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
